mul16_seq: RTL and testbench
============================

# mul16_seq

Sequential 16x16 unsigned shift-and-add multiplier built on the `Add16` adder. It sits directly downstream of `Add16` and feeds it one partial-product accumulation per clock. It accepts operands on a start strobe and runs for 16 cycles. It then presents a registered 32-bit product with a one-cycle done pulse. The ALU path uses it for multi-cycle multiply.

## Interface
- No parameters; operand width fixed at 16, product width fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `start` in 1: request; sampled only when `busy`=0.
- `a` in 16: multiplicand, captured at the accepting edge.
- `b` in 16: multiplier, captured at the accepting edge.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `product` is valid from this cycle.
- `product` out 32: unsigned a*b; holds its value until the next completion.

## Operation
- State machine has two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- Working register is P[32:0] = {c, hi[15:0], lo[15:0]}, plus multiplicand register M[15:0] and step counter cnt[4:0].
- IDLE with `start`=1: M<=a, hi<=0, c<=0, lo<=b, cnt<=0, go to RUN. `start`=0: stay in IDLE.
- Each RUN cycle performs one step:
  - If lo[0]=1: {c,hi} <= Add16(hi, M) with the carry reconstructed as c = (hi[15]&M[15]) | ((hi[15]^M[15]) & ~sum[15]). The `Add16` instance drops carry-out, so this reconstruction is mandatory.
  - Otherwise {c,hi} unchanged.
  - Then P <= P >> 1, with the new c set to 0, and cnt <= cnt+1.
- The step with cnt=15 completes the operation:
  - `product` <= next {hi,lo}.
  - `done` <= 1.
  - State goes to IDLE.
- `done` is registered and is 1 for exactly one cycle, otherwise 0.
- `start` while `busy`=1 is ignored; operands and result are unaffected.
- `start` in the cycle where `done`=1 is accepted (state is already IDLE), giving back-to-back operation.
- Arithmetic is unsigned. No overflow is possible because the product is 32 bits.
- Reset values (rst_n=0 at a rising edge): state IDLE, `busy`=0, `done`=0, `product`=0, P=0, M=0, cnt=0.
- Reset mid-operation aborts the run: no `done` pulse, and `product` is cleared to 0.
- `rst_n` takes priority over `start` at the same edge.

## Timing
- E0 = the edge where `start`=1 and `busy`=0.
- `busy`=1 from after E0 until after E16.
- Steps execute at E1..E16.
- `done`=1 and the new `product` are visible in the cycle after E16.
- Latency is 16 cycles from the accepting edge to `done`, and is independent of operand values unless the macro below is defined.
- Throughput is one result per 17 cycles back-to-back: the next accept happens at E17.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `MUL16_EARLY_EXIT_EN` defined:
  - In RUN, if lo[15-cnt:0] has no set bits remaining (all unconsumed multiplier bits are 0), the block completes in that cycle.
  - On completion, `product` is loaded with {hi,lo} shifted right by the remaining step count, using a right shifter on the 33-bit P.
  - RUN lasts max(1, msb_index(b)+1) cycles; b=0 completes after 1 RUN cycle.
  - The results are bit-identical to the fixed-latency mode.
- `MUL16_EARLY_EXIT_EN` undefined: latency is always 16 RUN cycles and no shifter is synthesized.

## Test plan
- Reset: hold rst_n=0 for 2 edges with `start`=1 -> `busy`=0, `done`=0, `product`=0, and no operation starts.
- Basic: a=3, b=5, start pulse -> `done` exactly 16 edges after the accepting edge, `product`=32'd15, `busy` low in the `done` cycle.
- Carry path: a=16'hFFFF, b=16'hFFFF -> `product`=32'hFFFE0001. Also a=16'h8000, b=16'h0002 -> `product`=32'h00010000.
- Busy protection: start a=100, b=200, then assert `start` with a=7, b=7 at step 5 -> single `done`, `product`=32'd20000. Then start a=7, b=7 in the `done` cycle -> accepted, next `product`=32'd49.
- Abort: start a=1234, b=5678, drive rst_n=0 at step 8 -> no `done`, `busy`=0, `product`=0. A fresh a=2, b=2 then gives 32'd4.
- Early exit: a=16'h1234, b=1 -> with `MUL16_EARLY_EXIT_EN`, `done` 1 edge after accept and `product`=32'h1234; without the macro, `done` 16 edges after accept with the same value.

Source files
------------

// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 unsigned shift-and-add multiplier.
// Takes one Add16 accumulation step per clock and runs for 16 steps.
// The registered 32-bit product comes with a one-cycle done pulse.
// Optional feature: define MUL16_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module mul16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic        c_q, c_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] m_q, m_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;
    logic        done_q, done_d;

    logic [15:0] sum;
    logic        carry;
    logic [32:0] p_add;
    logic [32:0] p_step;
    logic [31:0] p_final;
    logic        last_step;

    // Add16 drops its carry-out, so rebuild it from the operand and sum MSBs.
    assign sum   = hi_q + m_q;
    assign carry = (hi_q[15] & m_q[15]) | ((hi_q[15] ^ m_q[15]) & ~sum[15]);

    // Conditional add of the multiplicand, then shift the whole working register right.
    always_comb begin
        p_add  = lo_q[0] ? {carry, sum, lo_q} : {c_q, hi_q, lo_q};
        p_step = p_add >> 1;
    end

`ifdef MUL16_EARLY_EXIT_EN
    logic [15:0] live_mask;

    // lo[15-cnt:0] still holds unconsumed multiplier bits; bit 0 is consumed this step.
    assign live_mask = 16'hFFFF >> cnt_q;
    assign last_step = (cnt_q == 5'd15) || (((lo_q & live_mask) >> 1) == 16'd0);
    // Apply the skipped shifts in one go so the result matches the full 16-step run.
    assign p_final   = 32'(p_step >> (5'd15 - cnt_q));
`else
    assign last_step = (cnt_q == 5'd15);
    assign p_final   = p_step[31:0];
`endif

    // Next-state and datapath update; hold everything by default.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = a;
                    hi_d    = 16'd0;
                    c_d     = 1'b0;
                    lo_d    = b;
                    cnt_d   = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                c_d   = p_step[32];
                hi_d  = p_step[31:16];
                lo_d  = p_step[15:0];
                cnt_d = cnt_q + 5'd1;
                if (last_step) begin
                    product_d = p_final;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset also clears the product of an aborted run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q       <= 1'b0;
            hi_q      <= 16'd0;
            lo_q      <= 16'd0;
            m_q       <= 16'd0;
            cnt_q     <= 5'd0;
            product_q <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            c_q       <= c_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq; inputs change and outputs are sampled on negedge.
module tb_mul16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;
    int seen;

    mul16_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns at the negedge after the accepting edge.
    task automatic go(input logic [15:0] ta, input logic [15:0] tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen, starting from n0; bounded.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic int exp_lat(input logic [15:0] bv);
        int n = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
        if (n == 0) n = 1;
`ifndef MUL16_EARLY_EXIT_EN
        n = 16;
`endif
        return n;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'd3;
        b     = 16'd5;

        // Reset held for two edges with start asserted.
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_no_start", {31'd0, busy}, 32'd0);

        // Basic 3*5.
        go(16'd3, 16'd5);
        check("basic_busy", {31'd0, busy}, 32'd1);
        wait_done(0, lat);
        check("basic_lat", lat, exp_lat(16'd5));
        check("basic_product", product, 32'd15);
        check("basic_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("basic_pulse", {31'd0, done}, 32'd0);
        check("basic_hold", product, 32'd15);

        // Carry path.
        go(16'hFFFF, 16'hFFFF);
        wait_done(0, lat);
        check("ffff_lat", lat, exp_lat(16'hFFFF));
        check("ffff_product", product, 32'hFFFE0001);
        @(negedge clk);
        go(16'h8000, 16'h0002);
        wait_done(0, lat);
        check("8000_product", product, 32'h00010000);
        @(negedge clk);

        // Busy protection: start during run is ignored.
        go(16'd100, 16'd200);
        repeat (4) @(negedge clk);
        a     = 16'd7;
        b     = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat);
        check("busy_lat", lat, exp_lat(16'd200));
        check("busy_product", product, 32'd20000);
        // Back-to-back: start in the done cycle is accepted.
        go(16'd7, 16'd7);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_single_done", {31'd0, done}, 32'd0);
        check("b2b_hold", product, 32'd20000);
        wait_done(0, lat);
        check("b2b_lat", lat, exp_lat(16'd7));
        check("b2b_product", product, 32'd49);
        @(negedge clk);

        // Abort by reset mid-run.
        go(16'd1234, 16'd5678);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", product, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        go(16'd2, 16'd2);
        wait_done(0, lat);
        check("after_abort_product", product, 32'd4);
        @(negedge clk);

        // Early-exit vector; fixed 16-step latency when the feature is off.
        go(16'h1234, 16'h0001);
        wait_done(0, lat);
        check("early_lat", lat, exp_lat(16'h0001));
        check("early_product", product, 32'h00001234);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
